ahbl_sram_ctrl: RTL and testbench
=================================

// Module: ahbl_sram_ctrl
// PURPOSE
//   Parametrised AHB-Lite slave SRAM controller for the E902 instruction/data AHB-Lite port.
//   Successor to the fixed iahb memory controller. It adds:
//     - a configurable size and base address;
//     - independent read and write wait states;
//     - a two-cycle ERROR response for out-of-range, misaligned or oversized transfers;
//     - endian-selectable byte-lane steering.
//   Sits between the core's iahbl_pad_* bus and an internal register-array memory.
// PARAMETERS
//   ADDR_WIDTH  16        byte-address bits decoded; memory = 2^ADDR_WIDTH bytes (2^(ADDR_WIDTH-2) words)
//   BASE_ADDR   32'h0     region base; haddr[31:ADDR_WIDTH] must equal BASE_ADDR[31:ADDR_WIDTH]
//   WAIT_RD     0         read wait states, 0..15
//   WAIT_WR     0         write wait states, 0..15
// PORTS
//   pll_core_cpuclk   in   1   clock, all logic on rising edge
//   pad_cpu_rst_b     in   1   reset, asynchronous, active-low
//   lite_mmc_hsel     in   1   slave select
//   lite_yy_haddr     in   32  address-phase address
//   lite_yy_hsize     in   3   0=byte 1=half 2=word; >2 is an error
//   lite_yy_htrans    in   2   only NONSEQ(2'b10)/SEQ(2'b11) start a transfer
//   lite_yy_hwrite    in   1   1=write
//   lite_yy_hwdata    in   32  write data, valid in the data phase
//   pad_biu_bigend_b  in   1   0=big endian, 1=little endian (quasi-static)
//   mmc_lite_hrdata   out  32  read data
//   mmc_lite_hready   out  1   transfer done / bus ready
//   mmc_lite_hresp    out  2   2'b00 OKAY, 2'b01 ERROR; bit1 is always 0
// BEHAVIOUR
//   Reset values
//     - hready=1, hresp=00, hrdata=0, FSM=IDLE, counter=0.
//     - Memory contents are not reset.
//     - Reset asserted mid-transfer aborts the transfer; a pending write is discarded.
//   Accept condition
//     - A transfer is accepted when hsel & htrans[1] & hready are all 1 at a rising edge.
//     - On accept, haddr/hsize/hwrite are registered.
//     - hsel with IDLE/BUSY is not a transfer and gives a zero-wait OKAY.
//   Error check (at accept)
//     - out-of-range: haddr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH];
//     - oversized: hsize>2;
//     - misaligned: hsize==1 with haddr[0]=1, or hsize==2 with haddr[1:0]!=0.
//   FSM
//     - IDLE: no data phase; hready=1, hresp=OKAY.
//     - DATA: the counter loads WAIT_RD or WAIT_WR at accept.
//       - hready = (cnt==0); cnt decrements while nonzero.
//       - The data phase lasts WAIT+1 cycles.
//     - ERR1: hready=0, hresp=01; always followed by ERR2 on the next cycle.
//     - ERR2: hready=1, hresp=01.
//     - Leaving DATA (cnt==0) or ERR2: go to DATA or ERR1 if a new transfer is accepted
//       that cycle, else go to IDLE. Back-to-back transfers have no bubble.
//     - An erroring transfer never reads or writes memory.
//   Write
//     - mem[addr_q[ADDR_WIDTH-1:2]] is updated at the edge ending the data phase (hready=1).
//     - Only the addressed byte lanes are written, taken from the same lanes of hwdata.
//   Read
//     - hrdata = full word mem[addr_q] when hready=1 in a read DATA cycle.
//     - hrdata = 0 in all other cycles.
//     - A read immediately after a write to the same word returns the new data.
//   Lanes, little endian
//     - byte: lane = addr[1:0];
//     - half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
//   Lanes, big endian
//     - byte: lane = 3-addr[1:0];
//     - half: addr[1]=0 selects [31:16], addr[1]=1 selects [15:0].
//   Word transfers use all four lanes in either mode.
// TESTING
//   1. WAIT_WR=0/WAIT_RD=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back
//      -> both complete with hready=1 every cycle; read returns 0xDEADBEEF, OKAY.
//   2. Little endian: word 0x0 @0x20, then byte write 0xAA @0x21, then read @0x20
//      -> 0x0000AA00; repeat with bigend_b=0 -> 0x00AA0000.
//   3. WAIT_RD=3: read -> hready low for exactly 3 cycles, data valid on the 4th;
//      WAIT_WR=2 write -> 2 low cycles.
//   4. Read @BASE+2^ADDR_WIDTH, then word @0x2, then hsize=3
//      -> each gives ERR1 (hready=0, resp=01) then ERR2 (hready=1, resp=01);
//      memory unchanged, checked by readback.
//   5. Error followed by a NONSEQ accepted during ERR2 -> next data phase OKAY, no idle gap;
//      IDLE/BUSY with hsel=1 -> OKAY, zero wait.
//   6. Assert pad_cpu_rst_b=0 during the 2nd wait cycle of a write
//      -> hready=1, resp=00, hrdata=0 immediately; target word keeps its old value.

Source files
------------

// File: rtl/ahbl_sram_ctrl.sv
// rtl/ahbl_sram_ctrl.sv - AHB-Lite slave SRAM controller with wait states, ERROR responses and endian lane steering
module ahbl_sram_ctrl #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          WAIT_RD    = 0,
  parameter int          WAIT_WR    = 0
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst_b,
  input  logic        lite_mmc_hsel,
  input  logic [31:0] lite_yy_haddr,
  input  logic [2:0]  lite_yy_hsize,
  input  logic [1:0]  lite_yy_htrans,
  input  logic        lite_yy_hwrite,
  input  logic [31:0] lite_yy_hwdata,
  input  logic        pad_biu_bigend_b,
  output logic [31:0] mmc_lite_hrdata,
  output logic        mmc_lite_hready,
  output logic [1:0]  mmc_lite_hresp
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic [31:0]             mem [WORDS];

  logic                    accept;
  logic                    xfer_err;
  logic                    wr_done;
  logic [3:0]              wait_ld;
  logic [3:0]              wr_mask;
  logic [ADDR_WIDTH-3:0]   wr_idx;
  logic [ADDR_WIDTH-3:0]   rd_idx;
  logic [31:0]             rd_word;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a, input logic le);
    case (sz)
      2'd0:    lane_mask = le ? (4'b0001 << a) : (4'b1000 >> a);
      2'd1:    lane_mask = (a[1] ^ ~le) ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign accept   = lite_mmc_hsel & lite_yy_htrans[1] & mmc_lite_hready;
  assign xfer_err = ((lite_yy_haddr >> ADDR_WIDTH) != (BASE_ADDR >> ADDR_WIDTH))
                  || (lite_yy_hsize > 3'd2)
                  || (lite_yy_hsize == 3'd1 && lite_yy_haddr[0])
                  || (lite_yy_hsize == 3'd2 && lite_yy_haddr[1:0] != 2'b00);
  assign wait_ld  = lite_yy_hwrite ? 4'(WAIT_WR) : 4'(WAIT_RD);
  assign wr_done  = (state == S_DATA) && (cnt == 4'd0) && write_q;
  assign wr_mask  = lane_mask(size_q, addr_q[1:0], pad_biu_bigend_b);
  assign wr_idx   = addr_q[ADDR_WIDTH-1:2];
  // A waiting read fetches its own word; otherwise we may be fetching for a zero-wait read being accepted now.
  assign rd_idx   = (state == S_DATA && cnt != 4'd0) ? addr_q[ADDR_WIDTH-1:2]
                                                      : lite_yy_haddr[ADDR_WIDTH-1:2];

  // Forward a write completing this edge so a back-to-back read sees the new data.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_done && wr_idx == rd_idx) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) rd_word[8*b +: 8] = lite_yy_hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (wr_done) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= lite_yy_hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      addr_q          <= '0;
      size_q          <= 2'd0;
      write_q         <= 1'b0;
      mmc_lite_hready <= 1'b1;
      mmc_lite_hresp  <= 2'b00;
      mmc_lite_hrdata <= 32'h0;
    end else if (mmc_lite_hready) begin
      if (accept) begin
        addr_q  <= lite_yy_haddr[ADDR_WIDTH-1:0];
        size_q  <= lite_yy_hsize[1:0];
        write_q <= lite_yy_hwrite;
        if (xfer_err) begin
          state           <= S_ERR1;
          cnt             <= 4'd0;
          mmc_lite_hready <= 1'b0;
          mmc_lite_hresp  <= 2'b01;
          mmc_lite_hrdata <= 32'h0;
        end else begin
          state           <= S_DATA;
          cnt             <= wait_ld;
          mmc_lite_hready <= (wait_ld == 4'd0);
          mmc_lite_hresp  <= 2'b00;
          mmc_lite_hrdata <= (!lite_yy_hwrite && wait_ld == 4'd0) ? rd_word : 32'h0;
        end
      end else begin
        state           <= S_IDLE;
        cnt             <= 4'd0;
        mmc_lite_hready <= 1'b1;
        mmc_lite_hresp  <= 2'b00;
        mmc_lite_hrdata <= 32'h0;
      end
    end else if (state == S_ERR1) begin
      state           <= S_ERR2;
      mmc_lite_hready <= 1'b1;
      mmc_lite_hresp  <= 2'b01;
      mmc_lite_hrdata <= 32'h0;
    end else begin
      cnt             <= cnt - 4'd1;
      mmc_lite_hready <= (cnt == 4'd1);
      mmc_lite_hresp  <= 2'b00;
      mmc_lite_hrdata <= (!write_q && cnt == 4'd1) ? rd_word : 32'h0;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// tb/tb_ahbl_sram_ctrl.sv - directed self-checking bench for ahbl_sram_ctrl
module tb_ahbl_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic        bigend_b = 1'b1;
  logic        use1 = 1'b0;

  logic [31:0] rdata0, rdata1, rdata;
  logic        ready0, ready1, ready;
  logic [1:0]  resp0, resp1, resp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // dut0: zero waits, base 0; dut1: WAIT_RD=3, WAIT_WR=2, base 0x2000_0000
  ahbl_sram_ctrl #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_RD(0), .WAIT_WR(0)) dut0 (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .lite_mmc_hsel(hsel & ~use1),
    .lite_yy_haddr(haddr), .lite_yy_hsize(hsize), .lite_yy_htrans(htrans),
    .lite_yy_hwrite(hwrite), .lite_yy_hwdata(hwdata), .pad_biu_bigend_b(bigend_b),
    .mmc_lite_hrdata(rdata0), .mmc_lite_hready(ready0), .mmc_lite_hresp(resp0));

  ahbl_sram_ctrl #(.ADDR_WIDTH(12), .BASE_ADDR(32'h2000_0000), .WAIT_RD(3), .WAIT_WR(2)) dut1 (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .lite_mmc_hsel(hsel & use1),
    .lite_yy_haddr(haddr), .lite_yy_hsize(hsize), .lite_yy_htrans(htrans),
    .lite_yy_hwrite(hwrite), .lite_yy_hwdata(hwdata), .pad_biu_bigend_b(bigend_b),
    .mmc_lite_hrdata(rdata1), .mmc_lite_hready(ready1), .mmc_lite_hresp(resp1));

  assign rdata = use1 ? rdata1 : rdata0;
  assign ready = use1 ? ready1 : ready0;
  assign resp  = use1 ? resp1  : resp0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic exp_rdy, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    chk({tag, ".hready"}, {31'h0, ready}, {31'h0, exp_rdy});
    chk({tag, ".hresp"},  {30'h0, resp},  {30'h0, exp_resp});
    chk({tag, ".hrdata"}, rdata, exp_data);
  endtask

  task automatic set_addr(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
  endtask

  task automatic set_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    tick(); tick();
    rst_b = 1'b1;
    tick();
    chk_bus("reset0", 1'b1, 2'b00, 32'h0);

    // back-to-back word write and read, zero wait
    set_addr(32'h10, 3'd2, 1'b1);
    tick();
    chk_bus("t1.wr", 1'b1, 2'b00, 32'h0);
    hwdata = 32'hDEADBEEF;
    set_addr(32'h10, 3'd2, 1'b0);
    tick();
    chk_bus("t1.rd", 1'b1, 2'b00, 32'hDEADBEEF);
    set_idle();
    tick();
    chk_bus("t1.idle", 1'b1, 2'b00, 32'h0);

    // little-endian byte lane
    set_addr(32'h20, 3'd2, 1'b1);
    tick();
    hwdata = 32'h0;
    set_addr(32'h21, 3'd0, 1'b1);
    tick();
    hwdata = 32'h0000AA00;
    set_addr(32'h20, 3'd2, 1'b0);
    tick();
    chk_bus("t2.le", 1'b1, 2'b00, 32'h0000AA00);

    // big-endian byte lane
    bigend_b = 1'b0;
    set_addr(32'h20, 3'd2, 1'b1);
    tick();
    hwdata = 32'h0;
    set_addr(32'h21, 3'd0, 1'b1);
    tick();
    hwdata = 32'h00AA0000;
    set_addr(32'h20, 3'd2, 1'b0);
    tick();
    chk_bus("t2.be", 1'b1, 2'b00, 32'h00AA0000);
    // big-endian halfword at addr[1]=1 lands in [15:0]
    set_addr(32'h22, 3'd1, 1'b1);
    tick();
    hwdata = 32'h00001234;
    set_addr(32'h20, 3'd2, 1'b0);
    tick();
    chk_bus("t2.be_half", 1'b1, 2'b00, 32'h00AA1234);
    set_idle();
    bigend_b = 1'b1;
    tick();

    // known contents for the error checks
    set_addr(32'h0, 3'd2, 1'b1);
    tick();
    hwdata = 32'h11111111;
    set_addr(32'h4, 3'd2, 1'b1);
    tick();
    hwdata = 32'h22222222;
    set_idle();
    tick();

    // out-of-range read
    set_addr(32'h1000, 3'd2, 1'b0);
    tick();
    chk_bus("t4.oor.err1", 1'b0, 2'b01, 32'h0);
    set_idle();
    tick();
    chk_bus("t4.oor.err2", 1'b1, 2'b01, 32'h0);
    tick();
    chk_bus("t4.oor.idle", 1'b1, 2'b00, 32'h0);

    // misaligned word write
    set_addr(32'h2, 3'd2, 1'b1);
    tick();
    chk_bus("t4.mis.err1", 1'b0, 2'b01, 32'h0);
    set_idle();
    hwdata = 32'hFFFFFFFF;
    tick();
    chk_bus("t4.mis.err2", 1'b1, 2'b01, 32'h0);
    tick();

    // oversized write
    set_addr(32'h4, 3'd3, 1'b1);
    tick();
    chk_bus("t4.big.err1", 1'b0, 2'b01, 32'h0);
    set_idle();
    tick();
    chk_bus("t4.big.err2", 1'b1, 2'b01, 32'h0);
    tick();

    set_addr(32'h0, 3'd2, 1'b0);
    tick();
    chk_bus("t4.rb0", 1'b1, 2'b00, 32'h11111111);
    set_addr(32'h4, 3'd2, 1'b0);
    tick();
    chk_bus("t4.rb4", 1'b1, 2'b00, 32'h22222222);
    set_idle();
    tick();

    // NONSEQ accepted during ERR2, then IDLE/BUSY with hsel
    set_addr(32'h1000, 3'd2, 1'b0);
    tick();
    set_idle();
    tick();
    chk_bus("t5.err2", 1'b1, 2'b01, 32'h0);
    set_addr(32'h0, 3'd2, 1'b0);
    tick();
    chk_bus("t5.nogap", 1'b1, 2'b00, 32'h11111111);
    hsel = 1'b1; htrans = 2'b01;
    tick();
    chk_bus("t5.busy", 1'b1, 2'b00, 32'h0);
    hsel = 1'b1; htrans = 2'b00;
    tick();
    chk_bus("t5.idle", 1'b1, 2'b00, 32'h0);
    set_idle();

    // wait states on dut1
    use1 = 1'b1;
    set_addr(32'h2000_0040, 3'd2, 1'b1);
    tick();
    chk_bus("t3.wr.w1", 1'b0, 2'b00, 32'h0);
    set_idle();
    hwdata = 32'h12345678;
    tick();
    chk_bus("t3.wr.w2", 1'b0, 2'b00, 32'h0);
    tick();
    chk_bus("t3.wr.done", 1'b1, 2'b00, 32'h0);
    tick();
    set_addr(32'h2000_0040, 3'd2, 1'b0);
    tick();
    chk_bus("t3.rd.w1", 1'b0, 2'b00, 32'h0);
    set_idle();
    tick();
    chk_bus("t3.rd.w2", 1'b0, 2'b00, 32'h0);
    tick();
    chk_bus("t3.rd.w3", 1'b0, 2'b00, 32'h0);
    tick();
    chk_bus("t3.rd.done", 1'b1, 2'b00, 32'h12345678);
    tick();
    chk_bus("t3.idle", 1'b1, 2'b00, 32'h0);

    // reset during the second wait cycle of a write
    set_addr(32'h2000_0040, 3'd2, 1'b1);
    tick();
    set_idle();
    hwdata = 32'hCAFEF00D;
    tick();
    chk_bus("t6.w2", 1'b0, 2'b00, 32'h0);
    rst_b = 1'b0;
    #1;
    chk_bus("t6.rst", 1'b1, 2'b00, 32'h0);
    tick();
    rst_b = 1'b1;
    tick();
    set_addr(32'h2000_0040, 3'd2, 1'b0);
    tick();
    set_idle();
    tick(); tick(); tick();
    chk_bus("t6.keep", 1'b1, 2'b00, 32'h12345678);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
